// File: rtl/adpll_pkg.sv
// Shared types and default timing parameters for the ADPLL lock sequencer
// and its up/down pattern detector.
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_FREQ_ACQ  = 3'd2,
        ST_PHASE_ACQ = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    // DIR_NEU doubles as "no direction seen yet" when held as the last direction.
    typedef enum logic [1:0] {
        DIR_NEU = 2'd0,
        DIR_UP  = 2'd1,
        DIR_DN  = 2'd2
    } dir_e;

    localparam int DEF_RST_PULSE = 2;
    localparam int DEF_LOCK_CNT  = 16;
    localparam int DEF_LOSS_CNT  = 8;
    localparam int DEF_TIMEOUT   = 255;
    localparam int DEF_MAX_RETRY = 3;

    // Phase-detector outputs are active-low; both asserted is ambiguous and treated as neutral.
    function automatic dir_e decode_dir(input logic p_up, input logic p_down);
        dir_e d;
        d = DIR_NEU;
        if (!p_up && p_down) d = DIR_UP;
        else if (p_up && !p_down) d = DIR_DN;
        return d;
    endfunction

endpackage

// File: rtl/updn_pattern_detector.sv
// Decodes the phase-detector up/down pattern, remembers the last direction and
// maintains the lock-qualify and loss-run counters with look-ahead hit flags.
module updn_pattern_detector
    import adpll_pkg::*;
#(
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT
) (
    input  logic phase_clk_i,
    input  logic reset_n_i,
    input  logic p_up_i,
    input  logic p_down_i,
    input  logic clear_i,
    input  logic qual_en_i,
    input  logic run_en_i,
    output logic qual_hit_o,
    output logic run_hit_o
);

    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(LOSS_CNT + 1);
    localparam logic [QW-1:0] QUAL_MAX  = QW'(LOCK_CNT);
    localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_CNT - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(LOSS_CNT);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOSS_CNT - 1);

    dir_e          dir;
    dir_e          last_dir_q, last_dir_d;
    logic [QW-1:0] qual_q, qual_d;
    logic [RW-1:0] run_q, run_d;
    logic          is_repeat;

    always_comb begin
        dir        = decode_dir(p_up_i, p_down_i);
        is_repeat  = (dir != DIR_NEU) && (dir == last_dir_q);
        last_dir_d = last_dir_q;
        qual_d     = qual_q;
        run_d      = run_q;
        if (clear_i) begin
            last_dir_d = DIR_NEU;
            qual_d     = '0;
            run_d      = '0;
        end else begin
            if ((qual_en_i || run_en_i) && (dir != DIR_NEU))
                last_dir_d = dir;
            if (qual_en_i)
                qual_d = is_repeat ? '0 : ((qual_q == QUAL_MAX) ? qual_q : qual_q + 1'b1);
            if (run_en_i)
                run_d = !is_repeat ? '0 : ((run_q == RUN_MAX) ? run_q : run_q + 1'b1);
        end
    end

    // Hits look at the current sample so the FSM reacts on the same edge that samples it.
    assign qual_hit_o = qual_en_i && !clear_i && !is_repeat && (qual_q >= QUAL_LAST);
    assign run_hit_o  = run_en_i && !clear_i && is_repeat && (run_q >= RUN_LAST);

    always_ff @(posedge phase_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_dir_q <= DIR_NEU;
            qual_q     <= '0;
            run_q      <= '0;
        end else begin
            last_dir_q <= last_dir_d;
            qual_q     <= qual_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: rtl/adpll_lock_sequencer.sv
// Lock-acquisition sequencer: pulses the DCO controller reset, waits for frequency
// lock, qualifies phase lock, watches for loss and retries within a bounded budget.
module adpll_lock_sequencer
    import adpll_pkg::*;
#(
    parameter int RST_PULSE = DEF_RST_PULSE,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int LOSS_CNT  = DEF_LOSS_CNT,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic       phase_clk_i,
    input  logic       reset_n_i,
    input  logic       enable_i,
    input  logic       p_up_i,
    input  logic       p_down_i,
    input  logic       freq_lock_i,
    output logic       ctrl_reset_o,
    output logic       pll_lock_o,
    output logic       lock_lost_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(RST_PULSE + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
    localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRY);

    logic [1:0]    sync_q;
    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [PW-1:0] pulse_q;
    logic [1:0]    retry_q;
    logic          ctrl_reset_q, pll_lock_q, lock_lost_q, fail_q;
    logic          qual_hit, run_hit, retry_req;

    updn_pattern_detector #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT)
    ) u_detector (
        .phase_clk_i(phase_clk_i),
        .reset_n_i  (reset_n_i),
        .p_up_i     (p_up_i),
        .p_down_i   (p_down_i),
        .clear_i    (!(state_q == ST_PHASE_ACQ || state_q == ST_LOCKED)),
        .qual_en_i  (state_q == ST_PHASE_ACQ),
        .run_en_i   (state_q == ST_LOCKED),
        .qual_hit_o (qual_hit),
        .run_hit_o  (run_hit)
    );

    assign retry_req = ((state_q == ST_FREQ_ACQ) && (timer_q == TIMER_LAST)) ||
                       ((state_q == ST_PHASE_ACQ) && ((timer_q == TIMER_LAST) || !freq_lock_i));

    // Reset assertion is immediate; release only reaches the FSM after two flops.
    always_ff @(posedge phase_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) sync_q <= 2'b00;
        else            sync_q <= {sync_q[0], 1'b1};
    end

    always_ff @(posedge phase_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            ctrl_reset_q <= 1'b1;
            pll_lock_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
            fail_q       <= 1'b0;
            retry_q      <= '0;
            timer_q      <= '0;
            pulse_q      <= '0;
        end else if (sync_q[1]) begin
            lock_lost_q <= 1'b0;
            if (!enable_i) begin
                state_q      <= ST_IDLE;
                ctrl_reset_q <= 1'b1;
                pll_lock_q   <= 1'b0;
                fail_q       <= 1'b0;
                retry_q      <= '0;
                timer_q      <= '0;
                pulse_q      <= '0;
            end else if (retry_req) begin
                ctrl_reset_q <= 1'b1;
                timer_q      <= '0;
                pulse_q      <= '0;
                if (retry_q == RETRY_MAX) begin
                    state_q <= ST_FAIL;
                    fail_q  <= 1'b1;
                end else begin
                    state_q <= ST_RESET;
                    retry_q <= retry_q + 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_RESET;
                        ctrl_reset_q <= 1'b1;
                        retry_q      <= '0;
                        timer_q      <= '0;
                        pulse_q      <= '0;
                    end
                    ST_RESET: begin
                        if (pulse_q == PULSE_LAST) begin
                            state_q      <= ST_FREQ_ACQ;
                            ctrl_reset_q <= 1'b0;
                        end else begin
                            pulse_q <= pulse_q + 1'b1;
                        end
                    end
                    ST_FREQ_ACQ: begin
                        timer_q <= timer_q + 1'b1;
                        if (freq_lock_i) state_q <= ST_PHASE_ACQ;
                    end
                    ST_PHASE_ACQ: begin
                        timer_q <= timer_q + 1'b1;
                        if (qual_hit) begin
                            state_q    <= ST_LOCKED;
                            pll_lock_q <= 1'b1;
                            timer_q    <= '0;
                        end
                    end
                    // A loss from lock restarts with a fresh retry budget.
                    ST_LOCKED: begin
                        if (run_hit || !freq_lock_i) begin
                            state_q      <= ST_RESET;
                            ctrl_reset_q <= 1'b1;
                            pll_lock_q   <= 1'b0;
                            lock_lost_q  <= 1'b1;
                            retry_q      <= '0;
                            pulse_q      <= '0;
                            timer_q      <= '0;
                        end
                    end
                    ST_FAIL: begin
                        ctrl_reset_q <= 1'b1;
                        fail_q       <= 1'b1;
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        ctrl_reset_q <= 1'b1;
                        pll_lock_q   <= 1'b0;
                        fail_q       <= 1'b0;
                        retry_q      <= '0;
                    end
                endcase
            end
        end
    end

    assign ctrl_reset_o = ctrl_reset_q;
    assign pll_lock_o   = pll_lock_q;
    assign lock_lost_o  = lock_lost_q;
    assign fail_o       = fail_q;
    assign retry_cnt_o  = retry_q;
    assign state_o      = state_q;

endmodule

// File: doc/adpll_lock_sequencer.md
# adpll_lock_sequencer

Lock-acquisition sequencer for the all-digital PLL, sitting between system control and the DCO controller. It applies a reset pulse to the controller, waits for frequency lock, then qualifies phase lock from the phase-detector up/down pattern. It declares `pll_lock`, detects loss of lock, and performs bounded automatic re-acquisition with a timeout and retry budget.

## Interface
Parameters:
- `RST_PULSE`, 2: controller reset pulse length, in cycles (≥1).
- `LOCK_CNT`, 16: consecutive qualifying samples needed to declare phase lock.
- `LOSS_CNT`, 8: consecutive same-direction samples that declare loss of lock.
- `TIMEOUT`, 255: maximum cycles spent in FREQ_ACQ+PHASE_ACQ per attempt.
- `MAX_RETRY`, 3: re-acquisition attempts before FAIL.

Ports:
- `phase_clk` in 1: single clock; all flops on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 = run the sequence, 0 = return to IDLE.
- `p_up` in 1: phase-detector up, active-low (0 = raise DCO code).
- `p_down` in 1: phase-detector down, active-low.
- `freq_lock` in 1: frequency-lock flag from the DCO controller.
- `ctrl_reset` out 1: active-high reset to the DCO controller.
- `pll_lock` out 1: phase lock qualified.
- `lock_lost` out 1: one-cycle pulse on loss of lock.
- `fail` out 1: retry budget exhausted.
- `retry_cnt` out 2: attempts consumed in the current run.
- `state` out 3: current state encoding.

## Operation
- States and encoding: IDLE=0, RESET=1, FREQ_ACQ=2, PHASE_ACQ=3, LOCKED=4, FAIL=5. Encodings 6 and 7 fall back to IDLE.
- **Direction decode per sample:**
  - UP when p_up=0 and p_down=1.
  - DN when p_down=0 and p_up=1.
  - NEU when both are 1.
  - Both 0 is treated as NEU.
- `last_dir` holds the last non-NEU direction. It is cleared to none on entry to RESET.
- **IDLE:** ctrl_reset=1 and all counters are cleared. When enable=1, go to RESET.
- **RESET:** ctrl_reset=1 for exactly RST_PULSE cycles, then go to FREQ_ACQ. The attempt timer is cleared on entry.
- **FREQ_ACQ:** ctrl_reset=0.
  - freq_lock=1 → PHASE_ACQ, with the qualify counter cleared.
  - Timer reaching TIMEOUT → retry.
- **PHASE_ACQ:**
  - The qualify counter increments on NEU or on a direction opposite to last_dir. It clears on a repeat of last_dir.
  - The first non-NEU sample counts as qualifying.
  - Reaching LOCK_CNT → LOCKED.
  - Timer reaching TIMEOUT → retry.
  - freq_lock falling → retry.
- **LOCKED:**
  - pll_lock=1 and the timer is idle.
  - The run counter increments on a repeat of last_dir and resets to 0 otherwise.
  - Loss condition: the run counter reaches LOSS_CNT, or freq_lock=0.
  - On loss: lock_lost pulses, retry_cnt is cleared to 0, and the block goes to RESET. A loss from lock starts a fresh retry budget.
- **Retry:**
  - If retry_cnt==MAX_RETRY → FAIL.
  - Otherwise retry_cnt+1 and go to RESET.
- **FAIL:** fail=1 and ctrl_reset=1. The block stays in FAIL until enable=0.
- **enable=0 in any state:** go to IDLE on the next edge. pll_lock and fail are cleared at that edge. lock_lost is not pulsed.
- Priority within a cycle: enable=0 > loss/timeout/freq_lock drop > lock qualification.
- Counter widths use $clog2 of their limit and saturate at the limit; no wrap-around.

## Timing
- All outputs are registered.
- Reset values (reset_n=0, asynchronous):
  - state=IDLE, ctrl_reset=1, pll_lock=0, lock_lost=0, fail=0, retry_cnt=0.
- The controller samples on negedge. ctrl_reset, driven from posedge, is therefore stable for half a cycle before each controller edge.
- Latencies:
  - enable 0→1 to ctrl_reset deassert: RST_PULSE+1 cycles.
  - freq_lock=1 to state=PHASE_ACQ: 1 cycle.
  - LOCK_CNT-th qualifying sample to pll_lock=1: 1 cycle.
  - Loss sample to lock_lost=1: 1 cycle. pll_lock=0 in that same cycle, and ctrl_reset=1 in that same cycle.
- Reset asserted mid-operation: all outputs return to their reset values immediately. reset_n release is synchronized internally with a 2-flop synchronizer, so the first state change occurs ≥2 cycles after deassertion.

## Structure
- Shared package `adpll_pkg` contains the state enum (3-bit), the direction enum (UP/DN/NEU), and defaults for the timing parameters.
- One natural sub-module: `updn_pattern_detector`. It decodes p_up/p_down, holds last_dir, and provides the qualify and run counters with a clear input, plus `qual_hit` and `run_hit` flags.
- The top module holds the FSM, attempt timer, retry counter and reset synchronizer.

## Test plan
- **Nominal lock:** enable=1; freq_lock rises at cycle 10; p_up/p_down alternate UP,DN for 16 samples → pll_lock=1 one cycle after the 16th sample; retry_cnt=0.
- **Freq timeout:** freq_lock held 0 → RESET re-entered after 255 cycles, retry_cnt increments 1,2,3, then fail=1 on the 4th timeout with state=5.
- **Loss of lock:** in LOCKED, drive UP for 8 consecutive samples → lock_lost pulses exactly 1 cycle, pll_lock=0, ctrl_reset=1 for 2 cycles, retry_cnt=0.
- **Qualify break:** in PHASE_ACQ, drive UP,DN×7 then UP,UP → qualify counter clears and pll_lock is reached only after 16 further alternations; NEU samples count as qualifying.
- **Mid-run abort:** enable dropped while in PHASE_ACQ → state=IDLE next edge, ctrl_reset=1, no lock_lost pulse. Then reset_n pulsed low while in LOCKED → outputs immediately at reset values.
- **Freq drop:** freq_lock falls while in LOCKED → lock_lost pulse and restart from RESET.
